// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: default depth, NOP encoding
// and the packed entry layout {pc, instr, except, dslot}.
package inst_fetch_queue_pkg;

    localparam int          IQ_DEPTH  = 4;
    localparam int          PC_W      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    function automatic int iq_entry_w(input int data_w, input int exc_w);
        return PC_W + data_w + exc_w + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_iq_storage.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
module iq_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 73,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// First-word-fall-through instruction queue between IF and the if2id register,
// with synchronous flush and an optional empty-queue same-cycle bypass.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int DATA_W    = 32,
    parameter int EXC_W     = 8,
    parameter int AF_MARGIN = 1,
    parameter int BYPASS    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [31:0]                push_pc_i,
    input  logic [DATA_W-1:0]          push_instr_i,
    input  logic [EXC_W-1:0]           push_except_i,
    input  logic                       push_dslot_i,
    input  logic                       pop_ready_i,
    output logic                       pop_valid_o,
    output logic [31:0]                pop_pc_o,
    output logic [DATA_W-1:0]          pop_instr_o,
    output logic [EXC_W-1:0]           pop_except_o,
    output logic                       pop_dslot_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       almost_full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = iq_entry_w(DATA_W, EXC_W);
    localparam logic [EW-1:0] IDLE_ENTRY = {PC_W'(0), DATA_W'(NOP_INSTR), EXC_W'(0), 1'b0};

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] wdata, rdata, head;
    logic          empty, full, bypass, push_we, pop_fire;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign bypass = (BYPASS != 0) && empty && push_valid_i && pop_ready_i && !flush_i;

    // A bypassed entry is consumed straight from the inputs and never stored.
    assign push_we  = push_valid_i && !full && !flush_i && !bypass;
    assign pop_fire = pop_ready_i && !empty && !flush_i;

    assign push_ready_o  = !full;
    assign count_o       = count_q;
    assign almost_full_o = (int'(count_q) >= DEPTH - AF_MARGIN);
    assign pop_valid_o   = !flush_i && (!empty || bypass);

    assign wdata = {push_pc_i, push_instr_i, push_except_i, push_dslot_i};
    assign head  = !pop_valid_o ? IDLE_ENTRY : (bypass ? wdata : rdata);

    assign pop_pc_o     = head[EW-1 -: 32];
    assign pop_instr_o  = head[DATA_W+EXC_W -: DATA_W];
    assign pop_except_o = head[EXC_W:1];
    assign pop_dslot_o  = head[0];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_we)  wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_we && !pop_fire)      count_d = count_q + 1'b1;
            else if (pop_fire && !push_we) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .we_i    (push_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: queue-based reference model checked every
// cycle on the default instance, plus literal expectations on both instances.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_pc = '0;
    logic [31:0] push_instr = '0;
    logic [7:0]  push_except = '0;
    logic        push_dslot = 1'b0;
    logic        pop_ready = 1'b0;
    logic        push_ready, pop_valid, pop_dslot, almost_full;
    logic [31:0] pop_pc, pop_instr;
    logic [7:0]  pop_except;
    logic [2:0]  count;

    logic        b_push_valid = 1'b0;
    logic [31:0] b_push_pc = '0;
    logic        b_pop_ready = 1'b0;
    logic        b_push_ready, b_pop_valid, b_pop_dslot, b_almost_full;
    logic [31:0] b_pop_pc, b_pop_instr;
    logic [7:0]  b_pop_except;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .BYPASS(0)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .push_valid_i(push_valid), .push_ready_o(push_ready),
        .push_pc_i(push_pc), .push_instr_i(push_instr),
        .push_except_i(push_except), .push_dslot_i(push_dslot),
        .pop_ready_i(pop_ready), .pop_valid_o(pop_valid),
        .pop_pc_o(pop_pc), .pop_instr_o(pop_instr),
        .pop_except_o(pop_except), .pop_dslot_o(pop_dslot),
        .count_o(count), .almost_full_o(almost_full)
    );

    inst_fetch_queue #(.DEPTH(DEPTH), .BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .flush_i(1'b0),
        .push_valid_i(b_push_valid), .push_ready_o(b_push_ready),
        .push_pc_i(b_push_pc), .push_instr_i(32'h1234_5678),
        .push_except_i(8'h00), .push_dslot_i(1'b0),
        .pop_ready_i(b_pop_ready), .pop_valid_o(b_pop_valid),
        .pop_pc_o(b_pop_pc), .pop_instr_o(b_pop_instr),
        .pop_except_o(b_pop_except), .pop_dslot_o(b_pop_dslot),
        .count_o(b_count), .almost_full_o(b_almost_full)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of packed {pc, instr, except, dslot}.
    logic [72:0] mq[$];

    always @(posedge clk) begin
        int sz;
        sz = mq.size();
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (pop_ready && sz > 0) void'(mq.pop_front());
            if (push_valid && sz < DEPTH) mq.push_back({push_pc, push_instr, push_except, push_dslot});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        ev;
            logic [72:0] e;
            ev = !flush && (mq.size() > 0);
            e  = ev ? mq[0] : '0;
            chk("m_valid",  64'(pop_valid),  64'(ev));
            chk("m_pc",     64'(pop_pc),     64'(e[72:41]));
            chk("m_instr",  64'(pop_instr),  64'(e[40:9]));
            chk("m_except", 64'(pop_except), 64'(e[8:1]));
            chk("m_dslot",  64'(pop_dslot),  64'(e[0]));
            chk("m_count",  64'(count),      64'(mq.size()));
            chk("m_pready", 64'(push_ready), 64'(mq.size() < DEPTH));
            chk("m_afull",  64'(almost_full), 64'(mq.size() >= DEPTH - 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        push_valid  = 1'b1;
        push_pc     = pc;
        push_instr  = pc ^ 32'h5A5A_0000;
        push_except = pc[9:2];
        push_dslot  = pc[2];
    endtask

    initial begin
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_count",  64'(count), 64'd0);
        chk("rst_valid",  64'(pop_valid), 64'd0);
        chk("rst_pready", 64'(push_ready), 64'd1);
        chk("rst_afull",  64'(almost_full), 64'd0);
        chk("rst_pc",     64'(pop_pc), 64'd0);
        chk("rst_instr",  64'(pop_instr), 64'd0);

        // Fill and hold
        for (int i = 0; i < 4; i++) begin
            push(32'hBFC0_0000 + 32'(4*i));
            tick();
            #1;
            chk("fill_count",  64'(count), 64'(i+1));
            chk("fill_afull",  64'(almost_full), 64'(i+1 >= 3));
            chk("fill_pready", 64'(push_ready), 64'(i+1 < 4));
        end
        push(32'hBFC0_0010);
        tick();
        #1;
        chk("hold_count", 64'(count), 64'd4);
        tick();
        #1;
        chk("hold_count2", 64'(count), 64'd4);
        chk("hold_head",   64'(pop_pc), 64'hBFC0_0000);

        // Drain in order
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_valid", 64'(pop_valid), 64'd1);
            chk("drain_pc",    64'(pop_pc), 64'(32'hBFC0_0000 + 32'(4*k)));
            tick();
        end
        #1;
        chk("drain_empty", 64'(pop_valid), 64'd0);
        chk("drain_instr", 64'(pop_instr), 64'd0);
        chk("drain_count", 64'(count), 64'd0);

        // Steady push+pop at count 2, pointers wrap
        pop_ready = 1'b0;
        push(32'h0000_1000);
        tick();
        push(32'h0000_1004);
        tick();
        pop_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            push(32'h0000_1008 + 32'(4*j));
            #1;
            chk("wrap_pc",    64'(pop_pc), 64'(32'h0000_1000 + 32'(4*j)));
            chk("wrap_count", 64'(count), 64'd2);
            tick();
        end

        // Flush priority over push and pop
        pop_ready = 1'b0;
        push(32'h0000_2000);
        tick();
        #1;
        chk("pre_flush_count", 64'(count), 64'd3);
        flush     = 1'b1;
        pop_ready = 1'b1;
        push(32'hDEAD_0000);
        #1;
        chk("flush_valid", 64'(pop_valid), 64'd0);
        tick();
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        #1;
        chk("flush_count",  64'(count), 64'd0);
        chk("flush_pready", 64'(push_ready), 64'd1);
        chk("flush_valid2", 64'(pop_valid), 64'd0);
        tick();
        tick();

        // Reset mid-operation while pushing
        push(32'h0000_3000);
        tick();
        push(32'h0000_3004);
        tick();
        #1;
        chk("pre_rst_count", 64'(count), 64'd2);
        rst = 1'b1;
        push(32'h0000_3008);
        tick();
        rst        = 1'b0;
        push_valid = 1'b0;
        #1;
        chk("mrst_count",  64'(count), 64'd0);
        chk("mrst_valid",  64'(pop_valid), 64'd0);
        chk("mrst_pready", 64'(push_ready), 64'd1);
        chk("mrst_afull",  64'(almost_full), 64'd0);
        tick();

        // Bypass instance: same-cycle pass-through, then normal write
        b_push_valid = 1'b1;
        b_push_pc    = 32'h8000_0040;
        b_pop_ready  = 1'b1;
        #1;
        chk("bp_pc",    64'(b_pop_pc), 64'h8000_0040);
        chk("bp_valid", 64'(b_pop_valid), 64'd1);
        chk("bp_instr", 64'(b_pop_instr), 64'h1234_5678);
        chk("bp_count", 64'(b_count), 64'd0);
        tick();
        #1;
        chk("bp_count_next", 64'(b_count), 64'd0);
        b_pop_ready = 1'b0;
        #1;
        chk("bp_noready_valid", 64'(b_pop_valid), 64'd0);
        tick();
        b_push_valid = 1'b0;
        #1;
        chk("bp_store_count", 64'(b_count), 64'd1);
        chk("bp_store_valid", 64'(b_pop_valid), 64'd1);
        chk("bp_store_pc",    64'(b_pop_pc), 64'h8000_0040);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
